seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Time-multiplexed driver for an N-digit common-anode seven-segment display, sitting directly downstream of the decimal digit counters. Takes packed BCD digits plus decimal points, latches them tear-free at frame boundaries, scans one digit per slot, and drives active-low segment and anode lines. Segment encoding matches the single-digit decoder already in the design.

## Interface
- N_DIGITS, 4, number of scanned digits (2..8)
- SCAN_DIV, 50000, clk cycles per digit slot (>= BLANK_CYC+2)
- BLANK_CYC, 500, cycles at slot start with all anodes off (anti-ghosting)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bcd_in  in  4*N_DIGITS  packed BCD, digit 0 (least significant) in bits [3:0]
- dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit
- load  in  1  one-cycle strobe; captures bcd_in/dp_in
- seg  out  8  {a,b,c,d,e,f,g,dp}, active-low
- an  out  N_DIGITS  anode enables, active-low, at most one low
- frame_tick  out  1  one-cycle pulse when scan wraps to digit 0
- pending  out  1  captured value waiting for next frame boundary

## Operation
- Prescaler cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and index idx advances; idx N_DIGITS-1 wraps to 0 (wrap cycle).
- Two registers: pend_reg (written on load) and act_reg (displayed). On wrap cycle with pending=1, act_reg <= pend_reg, pending <= 0.
- load sets pending=1 and writes pend_reg. Repeated loads before wrap: last one wins.
- load on the wrap cycle: act_reg takes that cycle's bcd_in/dp_in directly; pending ends 0.
- Decode (active-low, dp bit excluded): 0=0000001x, 1=1001111x, 2=0010010x, 3=0000110x, 4=1001100x, 5=0100100x, 6=1100000x, 7=0001101x, 8=0000000x, 9=0000100x; 10..15 display dash 1111110x. dp bit = ~dp of current digit.
- Anode: an[idx]=0 when cnt >= BLANK_CYC and digit not blanked; all other bits 1. seg = 8'hFF whenever an is all ones.
- Reset (any cycle, including mid-slot or mid-load): cnt=0, idx=0, pend_reg=act_reg=0, pending=0, seg=8'hFF, an=all ones, frame_tick=0. Strobes during reset ignored.

## Timing
- seg, an, frame_tick registered: reflect cnt/idx/act_reg of previous cycle (1-cycle latency).
- frame_tick high exactly one cycle, the cycle after the wrap cycle; period N_DIGITS*SCAN_DIV.
- load to display: from 1 cycle (load on wrap cycle) up to N_DIGITS*SCAN_DIV+1 cycles.
- First lit anode after reset: cycle BLANK_CYC+1.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit k (k>0) is blanked (anode held off) when it and all higher digits of act_reg are 0 and their dp bits are 0; digit 0 never blanked.
- Undefined: all digits always displayed, zeros shown as 0.

## Structure
- Shared package seg7_pkg: SEG_* active-low patterns for 0..9 and dash, SEG_OFF = 8'hFF, segment bit-order constants.
- One sub-module: seg7_decode (combinational 4-bit BCD + dp -> 8-bit active-low pattern), reusable by the single-digit counters.
- Top holds prescaler, index, pend/act registers, blanking logic, output registers.

## Test plan
- Reset: assert reset 3 cycles mid-scan -> seg=8'hFF, an=4'hF, pending=0, idx restarts at 0.
- Scan (SCAN_DIV=8, BLANK_CYC=2): load bcd_in=16'h1234 -> after frame boundary, slot 0 shows seg=8'b10011001 an=4'b1110, slot 3 seg=8'b10011111 an=4'b0111; an all ones for first 2 cycles of each slot.
- Tearing: load 16'h5678 mid-frame -> pending=1, old value displayed until wrap, new value from next frame_tick; pending=0.
- Wrap collision: load 16'h0009 on wrap cycle -> pending never 1, digit 0 shows 8'b00001001 in next slot.
- Invalid/dp: bcd_in=16'h00A0, dp_in=4'b0010 -> digit 1 shows 8'b11111100.
- LEADING_ZERO_BLANK_EN: bcd_in=16'h0070 -> digits 3,2 keep an high, digit 1 shows 7, digit 0 shows 0; without macro all four anodes cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared active-low seven-segment patterns ({a,b,c,d,e,f,g,dp}, dp held off) and bit positions.
package seg7_pkg;
  localparam int SEG_A_BIT  = 7;
  localparam int SEG_B_BIT  = 6;
  localparam int SEG_C_BIT  = 5;
  localparam int SEG_D_BIT  = 4;
  localparam int SEG_E_BIT  = 3;
  localparam int SEG_F_BIT  = 2;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_DP_BIT = 0;
  localparam logic [7:0] SEG_0    = 8'b0000_0011;
  localparam logic [7:0] SEG_1    = 8'b1001_1111;
  localparam logic [7:0] SEG_2    = 8'b0010_0101;
  localparam logic [7:0] SEG_3    = 8'b0000_1101;
  localparam logic [7:0] SEG_4    = 8'b1001_1001;
  localparam logic [7:0] SEG_5    = 8'b0100_1001;
  localparam logic [7:0] SEG_6    = 8'b1100_0001;
  localparam logic [7:0] SEG_7    = 8'b0001_1011;
  localparam logic [7:0] SEG_8    = 8'b0000_0001;
  localparam logic [7:0] SEG_9    = 8'b0000_1001;
  localparam logic [7:0] SEG_DASH = 8'b1111_1101;
  localparam logic [7:0] SEG_OFF  = 8'hFF;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit plus decimal point to active-low segment pattern; non-BCD codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [7:0] pat;
  always_comb begin
    pat = SEG_DASH;
    case (bcd)
      4'd0: pat = SEG_0;
      4'd1: pat = SEG_1;
      4'd2: pat = SEG_2;
      4'd3: pat = SEG_3;
      4'd4: pat = SEG_4;
      4'd5: pat = SEG_5;
      4'd6: pat = SEG_6;
      4'd7: pat = SEG_7;
      4'd8: pat = SEG_8;
      4'd9: pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
  end
  // patterns carry dp off, so masking the dp position in yields ~dp
  assign seg = pat & {7'h7F, ~dp};
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: N-digit common-anode scan driver with frame-boundary latching and anti-ghost blanking.
// Optional leading-zero suppression when LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick,
  output logic                  pending
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] pend_bcd, act_bcd;
  logic [N_DIGITS-1:0]   pend_dp, act_dp, blank;
  logic [3:0]            digit;
  logic [7:0]            dec_seg;
  logic                  slot_end, wrap, lit;
  assign slot_end = cnt == CW'(SCAN_DIV - 1);
  assign wrap     = slot_end && idx == IW'(N_DIGITS - 1);
  assign digit    = 4'(act_bcd >> {idx, 2'b00});
  assign lit      = cnt >= CW'(BLANK_CYC) && !blank[idx];
`ifdef LEADING_ZERO_BLANK_EN
  logic zrun;
  always_comb begin
    blank = '0;
    zrun  = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      zrun     = zrun && act_bcd[4*k +: 4] == 4'd0 && !act_dp[k];
      blank[k] = zrun;
    end
  end
`else
  assign blank = '0;
`endif
  seg7_decode u_dec (
    .bcd (digit),
    .dp  (act_dp[idx]),
    .seg (dec_seg)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      pend_bcd   <= '0;
      pend_dp    <= '0;
      act_bcd    <= '0;
      act_dp     <= '0;
      pending    <= 1'b0;
      seg        <= SEG_OFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= wrap ? '0 : idx + 1'b1;
      if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
      end
      // a load landing on the wrap cycle bypasses the pending stage
      if (wrap && load) begin
        act_bcd <= bcd_in;
        act_dp  <= dp_in;
      end else if (wrap && pending) begin
        act_bcd <= pend_bcd;
        act_dp  <= pend_dp;
      end
      pending    <= wrap ? 1'b0 : (pending || load);
      seg        <= lit ? dec_seg : SEG_OFF;
      an         <= lit ? ~(N_DIGITS'(1) << idx) : '1;
      frame_tick <= wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed stimulus with a per-cycle scoreboard model plus targeted pattern checks.
module tb_seg7_scan_mux;
  localparam int N = 4, SD = 8, BC = 2;
  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       ft;
    logic       pend;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b1, load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick, pending;
  int          total = 0, passed = 0;
  exp_t        sb[$];
  int          m_cnt = 0, m_idx = 0;
  logic [15:0] m_act = '0, m_pend = '0;
  logic [3:0]  m_adp = '0, m_pdp = '0;
  logic        m_pending = 1'b0;
  seg7_scan_mux #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .pending    (pending)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] ref_pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b1100000;
      4'd7: return 7'b0001101;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic model(output exp_t e);
    logic [3:0] blank, d;
    logic       wrap, lit;
    if (reset) begin
      e = '{8'hFF, 4'hF, 1'b0, 1'b0};
      m_cnt = 0; m_idx = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pending = 1'b0;
    end else begin
      blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
      for (int k = 1; k < N; k++) blank[k] = (m_act >> (4 * k)) == 16'd0 && (m_adp >> k) == 4'd0;
`endif
      wrap = m_cnt == SD - 1 && m_idx == N - 1;
      d = 4'(m_act >> (4 * m_idx));
      lit = m_cnt >= BC && !blank[m_idx];
      e.seg = lit ? {ref_pat(d), ~m_adp[m_idx]} : 8'hFF;
      e.an = lit ? ~(4'b0001 << m_idx) : 4'hF;
      e.ft = wrap;
      if (wrap) begin
        if (load) begin m_act = bcd_in; m_adp = dp_in; end
        else if (m_pending) begin m_act = m_pend; m_adp = m_pdp; end
        m_pending = 1'b0;
      end else if (load) m_pending = 1'b1;
      if (load) begin m_pend = bcd_in; m_pdp = dp_in; end
      e.pend = m_pending;
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
      end else m_cnt++;
    end
  endtask
  task automatic step();
    exp_t e;
    model(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cycle", {17'd0, seg, an, frame_tick, pending}, {17'd0, e});
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic do_load(input logic [15:0] b, input logic [3:0] p);
    load = 1'b1; bcd_in = b; dp_in = p;
    step();
    load = 1'b0;
  endtask
  task automatic wait_ft();
    int n = 0;
    do begin step(); n++; end while (!frame_tick && n < 4 * N * SD);
    chk("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask
  initial begin
    steps(3);
    chk("reset_seg", {24'd0, seg}, 32'hFF);
    chk("reset_an", {28'd0, an}, 32'hF);
    reset = 1'b0;
    steps(2);
    chk("blank_an", {28'd0, an}, 32'hF);
    step();
    chk("first_lit_an", {28'd0, an}, 32'b1110);
    chk("first_lit_seg", {24'd0, seg}, 32'b00000011);
    do_load(16'h1234, 4'b0000);
    chk("load_pending", {31'd0, pending}, 32'd1);
    wait_ft();
    chk("wrap_pending_clear", {31'd0, pending}, 32'd0);
    steps(2);
    chk("slot0_blank", {28'd0, an}, 32'hF);
    step();
    chk("slot0_seg", {24'd0, seg}, 32'b10011001);
    chk("slot0_an", {28'd0, an}, 32'b1110);
    steps(24);
    chk("slot3_seg", {24'd0, seg}, 32'b10011111);
    chk("slot3_an", {28'd0, an}, 32'b0111);
    do_load(16'h5678, 4'b0000);
    chk("tear_pending", {31'd0, pending}, 32'd1);
    chk("tear_old_seg", {24'd0, seg}, 32'b10011111);
    wait_ft();
    chk("tear_pending_clear", {31'd0, pending}, 32'd0);
    steps(3);
    chk("tear_new_seg", {24'd0, seg}, 32'b00000001);
    for (int i = 0; i < 2 * N * SD && !(m_cnt == SD - 1 && m_idx == N - 1); i++) step();
    chk("at_wrap", {31'd0, m_cnt == SD - 1 && m_idx == N - 1}, 32'd1);
    do_load(16'h0009, 4'b0000);
    chk("collide_pending", {31'd0, pending}, 32'd0);
    chk("collide_ft", {31'd0, frame_tick}, 32'd1);
    steps(3);
    chk("collide_seg", {24'd0, seg}, 32'b00001001);
    do_load(16'h00A0, 4'b0010);
    wait_ft();
    steps(11);
    chk("dash_dp_seg", {24'd0, seg}, 32'b11111100);
    chk("dash_dp_an", {28'd0, an}, 32'b1101);
    do_load(16'h0070, 4'b0000);
    wait_ft();
    steps(3);
    chk("lz_d0_seg", {24'd0, seg}, 32'b00000011);
    steps(8);
    chk("lz_d1_seg", {24'd0, seg}, 32'b00011011);
    steps(8);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d2_an", {28'd0, an}, 32'hF);
    steps(8);
    chk("lz_d3_an", {28'd0, an}, 32'hF);
`else
    chk("lz_d2_an", {28'd0, an}, 32'b1011);
    steps(8);
    chk("lz_d3_an", {28'd0, an}, 32'b0111);
`endif
    steps(5);
    reset = 1'b1; load = 1'b1; bcd_in = 16'hFFFF; dp_in = 4'hF;
    steps(3);
    chk("midreset_seg", {24'd0, seg}, 32'hFF);
    chk("midreset_an", {28'd0, an}, 32'hF);
    chk("midreset_pending", {31'd0, pending}, 32'd0);
    load = 1'b0; reset = 1'b0;
    steps(3);
    chk("restart_an", {28'd0, an}, 32'b1110);
    chk("restart_seg", {24'd0, seg}, 32'b00000011);
    steps(2 * N * SD);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
